// File: rtl/toggle_pulse_gen_if.sv
// Control-side bundle for toggle_pulse_gen: request/config inputs and pulse/status outputs.
// With PHASE_CHECK_EN defined it also carries the TFF feedback (Q_fb) and the sticky Mismatch flag.
interface toggle_pulse_gen_if #(
    parameter int PER_W = 8,
    parameter int CNT_W = 8
);
    logic             Start;
    logic             Stop;
    logic             Mode;
    logic [PER_W-1:0] Period;
    logic [CNT_W-1:0] Burst;
    logic             T;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Pulses;
    logic             Q_model;
`ifdef PHASE_CHECK_EN
    logic             Q_fb;
    logic             Mismatch;
`endif

    modport master (
        output Start, Stop, Mode, Period, Burst,
`ifdef PHASE_CHECK_EN
        output Q_fb,
        input  Mismatch,
`endif
        input  T, Busy, Done, Pulses, Q_model
    );

    modport slave (
        input  Start, Stop, Mode, Period, Burst,
`ifdef PHASE_CHECK_EN
        input  Q_fb,
        output Mismatch,
`endif
        output T, Busy, Done, Pulses, Q_model
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Periodic single-cycle T pulse generator (continuous or counted burst) with a model of the downstream TFF's Q.
// Optional macro PHASE_CHECK_EN adds a sticky Mismatch flag comparing Q_fb against the modelled Q.
module toggle_pulse_gen #(
    parameter int PER_W = 8,
    parameter int CNT_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    toggle_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             mode_q, mode_d;
    logic             t_q, t_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             qm_q, qm_d;
    logic             accept;
    logic [PER_W-1:0] period_eff;
    logic [CNT_W-1:0] pulses_inc;

    // A zero period behaves as one so T can never stall in RUN.
    assign period_eff = (bus.Period == '0) ? PER_W'(1) : bus.Period;
    assign pulses_inc = pulses_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        burst_d  = burst_q;
        mode_d   = mode_q;
        pulses_d = pulses_q;
        t_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        qm_d     = qm_q ^ t_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Stop) begin
                    accept   = 1'b1;
                    per_d    = period_eff;
                    burst_d  = bus.Burst;
                    mode_d   = bus.Mode;
                    pulses_d = '0;
                    cnt_d    = period_eff - 1'b1;
                    if (bus.Mode && (bus.Burst == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    t_d      = 1'b1;
                    pulses_d = pulses_inc;
                    cnt_d    = per_q - 1'b1;
                    // The edge that issues the final burst pulse also retires the sequence.
                    if (mode_q && (pulses_inc == burst_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            per_q    <= '0;
            burst_q  <= '0;
            mode_q   <= 1'b0;
            t_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pulses_q <= '0;
            qm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            burst_q  <= burst_d;
            mode_q   <= mode_d;
            t_q      <= t_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pulses_q <= pulses_d;
            qm_q     <= qm_d;
        end
    end

    assign bus.T       = t_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Pulses  = pulses_q;
    assign bus.Q_model = qm_q;

`ifdef PHASE_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Feedback is compared against the Q prediction held during the same cycle.
    always_comb begin
        mismatch_d = mismatch_q | (bus.Q_fb != qm_q);
        if (accept) begin
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.Mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: directed vectors, a per-edge behavioural model and literal pins.
// Covers the PHASE_CHECK_EN Mismatch flag when that macro is defined.
module tb_toggle_pulse_gen;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    bit   check_en;

    toggle_pulse_gen_if #(.PER_W(8), .CNT_W(8)) bus ();

    toggle_pulse_gen #(.PER_W(8), .CNT_W(8)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: sequence phase and the parameters captured at the accepted Start.
    int ecount;
    int phase;
    int start_e;
    int m_p;
    int m_b;
    int m_m;
    int exp_t;
    int exp_busy;
    int exp_done;
    int exp_pulses;
    int exp_q;
    int exp_mis;

    initial begin
        ecount = 0; phase = 0; start_e = 0; m_p = 1; m_b = 0; m_m = 0;
        exp_t = 0; exp_busy = 0; exp_done = 0; exp_pulses = 0; exp_q = 0; exp_mis = 0;
    end

    always @(posedge clk) begin : model
        int e, n_phase, n_start, n_p, n_b, n_m, n_t, n_busy, n_done, n_pulses, n_q, n_mis, fb, idx;
        e = ecount + 1;
        n_phase = phase; n_start = start_e; n_p = m_p; n_b = m_b; n_m = m_m;
        n_t = 0; n_busy = 0; n_done = 0; n_pulses = exp_pulses; n_q = exp_q ^ exp_t;
        n_mis = exp_mis;
        fb = 0;
`ifdef PHASE_CHECK_EN
        fb = int'(bus.Q_fb);
        if (fb != exp_q) n_mis = 1;
`endif
        if (!rst_n) begin
            n_phase = 0; n_t = 0; n_busy = 0; n_done = 0; n_pulses = 0; n_q = 0; n_mis = 0;
        end else if (phase == 0) begin
            if (bus.Start && !bus.Stop) begin
                n_p = (bus.Period == 0) ? 1 : int'(bus.Period);
                n_b = int'(bus.Burst);
                n_m = int'(bus.Mode);
                n_start = e;
                n_pulses = 0;
                n_mis = 0;
                if (n_m == 1 && n_b == 0) begin
                    n_phase = 2; n_done = 1;
                end else begin
                    n_phase = 1; n_busy = 1;
                end
            end
        end else if (phase == 1) begin
            if (bus.Stop) begin
                n_phase = 0;
            end else if ((e - start_e) % m_p == 0) begin
                idx = (e - start_e) / m_p;
                n_t = 1;
                n_pulses = (exp_pulses + 1) % 256;
                if (m_m == 1 && idx == m_b) begin
                    n_phase = 2; n_done = 1;
                end else begin
                    n_busy = 1;
                end
            end else begin
                n_busy = 1;
            end
        end else begin
            n_phase = 0;
        end
        ecount <= e; phase <= n_phase; start_e <= n_start; m_p <= n_p; m_b <= n_b; m_m <= n_m;
        exp_t <= n_t; exp_busy <= n_busy; exp_done <= n_done; exp_pulses <= n_pulses;
        exp_q <= n_q; exp_mis <= n_mis;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_T", 32'(bus.T), 32'(exp_t));
            checkOutput("model_Busy", 32'(bus.Busy), 32'(exp_busy));
            checkOutput("model_Done", 32'(bus.Done), 32'(exp_done));
            checkOutput("model_Pulses", 32'(bus.Pulses), 32'(exp_pulses));
            checkOutput("model_Q", 32'(bus.Q_model), 32'(exp_q));
`ifdef PHASE_CHECK_EN
            checkOutput("model_Mismatch", 32'(bus.Mismatch), 32'(exp_mis));
`endif
        end
    end

    task automatic applyStimulus(input logic start, input logic stop, input logic mode,
                                 input logic [7:0] period, input logic [7:0] burst);
        bus.Start  = start;
        bus.Stop   = stop;
        bus.Mode   = mode;
        bus.Period = period;
        bus.Burst  = burst;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, bus.Mode, bus.Period, bus.Burst);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        compared = 0; mismatched = 0; check_en = 1'b0;
        rst_n = 1'b0;
        bus.Start = 1'b1; bus.Stop = 1'b0; bus.Mode = 1'b0; bus.Period = 8'd0; bus.Burst = 8'd0;
`ifdef PHASE_CHECK_EN
        bus.Q_fb = 1'b0;
`endif
        // Reset held with Start high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_en = 1'b1;
            checkOutput("rst_T", 32'(bus.T), 0);
            checkOutput("rst_Busy", 32'(bus.Busy), 0);
            checkOutput("rst_Pulses", 32'(bus.Pulses), 0);
            checkOutput("rst_Q", 32'(bus.Q_model), 0);
        end
        bus.Start = 1'b0;
        rst_n = 1'b1;
        idle(1);
        checkOutput("post_rst_Busy", 32'(bus.Busy), 0);

        // Continuous, period 4, with an ignored Start/Period change mid-run.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 8'd0);
        checkOutput("cont_busy", 32'(bus.Busy), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, 8'd0);
        idle(2);
        checkOutput("cont_T_k3", 32'(bus.T), 0);
        idle(1);
        checkOutput("cont_T_k4", 32'(bus.T), 1);
        checkOutput("cont_P_k4", 32'(bus.Pulses), 1);
        idle(1);
        checkOutput("cont_Q_k5", 32'(bus.Q_model), 1);
        idle(8);
        checkOutput("cont_P_k13", 32'(bus.Pulses), 3);
        checkOutput("cont_Q_k13", 32'(bus.Q_model), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd4, 8'd0);
        checkOutput("cont_stop_busy", 32'(bus.Busy), 0);

        // Burst of 3 at period 2.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'd3);
        idle(5);
        checkOutput("burst_T_k5", 32'(bus.T), 0);
        idle(1);
        checkOutput("burst_Done", 32'(bus.Done), 1);
        checkOutput("burst_T_k6", 32'(bus.T), 1);
        checkOutput("burst_Busy_k6", 32'(bus.Busy), 0);
        checkOutput("burst_P", 32'(bus.Pulses), 3);
        idle(1);
        checkOutput("burst_Done_off", 32'(bus.Done), 0);
        checkOutput("burst_Q", 32'(bus.Q_model), 1);

        // Zero-length burst.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
        checkOutput("b0_Done", 32'(bus.Done), 1);
        checkOutput("b0_T", 32'(bus.T), 0);
        idle(1);
        checkOutput("b0_Pulses", 32'(bus.Pulses), 0);

        // Period 0 acts as 1: continuous T, Pulses wraps after 256.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        idle(1);
        checkOutput("p0_T", 32'(bus.T), 1);
        idle(256);
        checkOutput("p0_wrap", 32'(bus.Pulses), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        checkOutput("p0_stop_T", 32'(bus.T), 0);
        checkOutput("p0_stop_P", 32'(bus.Pulses), 1);

        // Stop on the edge a pulse is due, then Start+Stop together in IDLE.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        idle(5);
        checkOutput("stop_P_pre", 32'(bus.Pulses), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'd0);
        checkOutput("stop_T", 32'(bus.T), 0);
        checkOutput("stop_P", 32'(bus.Pulses), 1);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 8'd0);
        checkOutput("startstop_Busy", 32'(bus.Busy), 0);
        idle(2);
        checkOutput("startstop_Busy2", 32'(bus.Busy), 0);

        // Reset in the middle of a run.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        idle(4);
        doReset();
        checkOutput("midrst_Q", 32'(bus.Q_model), 0);
        checkOutput("midrst_Busy", 32'(bus.Busy), 0);
        idle(2);

`ifdef PHASE_CHECK_EN
        // Feedback stuck at 0 against a toggling prediction.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        idle(2);
        checkOutput("mis_before", 32'(bus.Mismatch), 0);
        idle(1);
        checkOutput("mis_set", 32'(bus.Mismatch), 1);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        idle(2);
        checkOutput("mis_sticky", 32'(bus.Mismatch), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        checkOutput("mis_clear", 32'(bus.Mismatch), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        idle(2);
`endif

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
